boss_action_sched: RTL and testbench
====================================

// Module: boss_action_sched
// PURPOSE
//  Per-frame action scheduler for the boss. Picks the player target by aggro (with hysteresis).
//  Sequences jump requests to the boss movement datapath and projectile volleys.
//  Escalates attack phase from boss HP. Sits between player/aggro logic and boss_move/boss_projectile.
// PARAMETERS
//  HP_PH2=8'd140        HP at/below which phase 2 is entered
//  HP_PH3=8'd60         HP at/below which phase 3 (enrage) is entered
//  WAIT_P1/P2/P3=30/20/10  ground wait in frames per phase
//  STEP_P1/P2/P3=5/6/8  move_step output per phase
//  JUMPS_PER_VOLLEY=3   jumps between projectile volleys
//  SHOT_GAP=8           frames between shots in a volley
//  AGGRO_HYST=4'd2      aggro margin needed to switch target
//  JUMP_TIMEOUT=120     max frames in JUMP before forced return to WAIT
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous reset, active low
//  frame_tick      in   1   1-clk pulse per video frame
//  game_active     in   2   0=reset state, 1=running, 2/3=frozen
//  boss_hp         in   8   current boss HP
//  boss_x          in   12  boss position from movement block
//  boss_grounded   in   1   1 while boss is on ground
//  char_x, player_2_x          in  12  player x positions
//  char_aggro, player_2_aggro  in  4   aggro levels
//  char_alive, player_2_alive  in  1   player alive flags
//  target_sel      out  1   0=char, 1=player_2
//  target_x        out  12  x of selected target
//  jump_req        out  1   1-clk pulse: start jump
//  jump_dir        out  1   0=left, 1=right; valid from jump_req onward
//  move_step       out  4   horizontal step for current phase
//  fire_req        out  1   1-clk pulse: launch one projectile
//  phase           out  2   1..3 attack phase
//  enraged         out  1   1 when phase==3
// BEHAVIOUR
//  Reset (rst_n=0, async): target_sel=0, target_x=0, jump_req=0, jump_dir=1, move_step=STEP_P1,
//   fire_req=0, phase=1, enraged=0, FSM=IDLE, all counters 0.
//  game_active==0: synchronous return to the reset values on the next clk. Takes effect mid-jump or mid-volley.
//  game_active==2/3: all state frozen; no pulses.
//  All updates happen only on the cycle frame_tick=1 with game_active==1. Outputs are registered (1-clk latency).
//  Target arbitration (each tick):
//   - Switch to the other player if the current target is dead and the other is alive.
//   - Otherwise switch if other_aggro >= cur_aggro + AGGRO_HYST. Compute in 5 bits; no wrap.
//   - If both players are dead, hold target_sel.
//   - target_x follows the selected player each tick.
//  Phase: computed from boss_hp against HP_PH2 and HP_PH3. Monotonic: phase never decreases until reset or game_active==0.
//   move_step and wait length follow the phase.
//  FSM states:
//   IDLE -> WAIT on first running tick; loads the wait counter with WAIT_Pn.
//   WAIT: decrement on each tick while boss_grounded. At 0 and at least one player alive -> JUMP.
//    On entry to JUMP: pulse jump_req; jump_dir = (target_x < boss_x) ? 0 : 1.
//    Both players dead: stay in WAIT with counter held at 0, no requests.
//   JUMP: wait for boss_grounded 1->0->1, or JUMP_TIMEOUT ticks.
//    Then increment the jump count. If jump count == JUMPS_PER_VOLLEY: count=0 -> FIRE. Else -> WAIT (reload).
//   FIRE: shots = phase (1/2/3). First fire_req on the first tick in FIRE; next ones every SHOT_GAP ticks.
//    After the last shot -> WAIT (reload).
//  Phase change during FIRE does not change the shot count of the current volley.
//  Phase change during WAIT takes effect at the next reload.
//  jump_req and fire_req are never asserted in the same cycle, and never for more than 1 clk.
// CONFIGURATION
//  BOSS_ENRAGE_EN defined:
//   - phase 3 is reachable and enraged=(phase==3).
//   - In phase 3, FIRE is also entered after every jump (JUMPS_PER_VOLLEY treated as 1).
//  BOSS_ENRAGE_EN undefined:
//   - phase saturates at 2 and enraged is tied 0.
//   - HP_PH3, WAIT_P3 and STEP_P3 are unused.
// TESTING
//  rst_n low mid-JUMP -> all outputs at reset values immediately (async); FSM=IDLE.
//  Aggro char=5, p2=6 -> target_sel stays 0. p2=7 -> target_sel=1 one clk after the next tick.
//  Run, grounded, hp=200 -> first jump_req exactly 31 ticks after start; jump_dir=0 when target_x=100, boss_x=960.
//  Three jumps with the grounded 1->0->1 sequence -> one fire_req, then WAIT. hp=100 -> 2 fire_req, 8 ticks apart.
//  Grounded stuck at 1 in JUMP -> return to WAIT after 120 ticks; no extra jump_req.
//  BOSS_ENRAGE_EN, hp 200->50->200 -> phase 1->3 and stays 3, enraged=1, move_step=8. Both players dead -> no pulses.

Source files
------------

// File: rtl/boss_action_sched_if.sv
// Signal bundle between the boss action scheduler and the game side (players, HP, movement, projectiles).
// master = scheduler side, slave = game/environment side.
interface boss_action_sched_if;
  logic        frame_tick;
  logic [1:0]  game_active;
  logic [7:0]  boss_hp;
  logic [11:0] boss_x;
  logic        boss_grounded;
  logic [11:0] char_x;
  logic [11:0] player_2_x;
  logic [3:0]  char_aggro;
  logic [3:0]  player_2_aggro;
  logic        char_alive;
  logic        player_2_alive;
  logic        target_sel;
  logic [11:0] target_x;
  logic        jump_req;
  logic        jump_dir;
  logic [3:0]  move_step;
  logic        fire_req;
  logic [1:0]  phase;
  logic        enraged;

  modport master (
    input  frame_tick, game_active, boss_hp, boss_x, boss_grounded,
           char_x, player_2_x, char_aggro, player_2_aggro, char_alive, player_2_alive,
    output target_sel, target_x, jump_req, jump_dir, move_step, fire_req, phase, enraged
  );

  modport slave (
    output frame_tick, game_active, boss_hp, boss_x, boss_grounded,
           char_x, player_2_x, char_aggro, player_2_aggro, char_alive, player_2_alive,
    input  target_sel, target_x, jump_req, jump_dir, move_step, fire_req, phase, enraged
  );
endinterface

// File: rtl/boss_action_sched.sv
// Per-frame boss scheduler: aggro target pick, jump/volley sequencing, HP-driven phase escalation.
// Optional feature macro: BOSS_ENRAGE_EN (phase 3 / enrage, volley after every jump in phase 3).
module boss_action_sched #(
  parameter logic [7:0] HP_PH2           = 8'd140,
  parameter logic [7:0] HP_PH3           = 8'd60,
  parameter logic [7:0] WAIT_P1          = 8'd30,
  parameter logic [7:0] WAIT_P2          = 8'd20,
  parameter logic [7:0] WAIT_P3          = 8'd10,
  parameter logic [3:0] STEP_P1          = 4'd5,
  parameter logic [3:0] STEP_P2          = 4'd6,
  parameter logic [3:0] STEP_P3          = 4'd8,
  parameter logic [3:0] JUMPS_PER_VOLLEY = 4'd3,
  parameter logic [3:0] SHOT_GAP         = 4'd8,
  parameter logic [3:0] AGGRO_HYST       = 4'd2,
  parameter logic [7:0] JUMP_TIMEOUT     = 8'd120
) (
  input logic                 clk,
  input logic                 rst_n,
  boss_action_sched_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_JUMP, S_FIRE} state_t;

  state_t      r_state;
  logic        r_target_sel;
  logic [11:0] r_target_x;
  logic        r_jump_req;
  logic        r_jump_dir;
  logic [3:0]  r_move_step;
  logic        r_fire_req;
  logic [1:0]  r_phase;
  logic        r_enraged;
  logic [7:0]  r_wait;
  logic [7:0]  r_jtick;
  logic        r_air;
  logic [3:0]  r_jumps;
  logic [1:0]  r_shots;
  logic [3:0]  r_gap;

  logic        w_tick;
  logic        w_cur_alive;
  logic        w_oth_alive;
  logic [4:0]  w_cur_aggro;
  logic [4:0]  w_oth_aggro;
  logic        w_sel_n;
  logic [11:0] w_tx_n;
  logic [1:0]  w_hp_raw;
  logic [1:0]  w_hp_phase;
  logic [1:0]  w_phase_n;
  logic [7:0]  w_wait_len;
  logic [3:0]  w_step_n;
  logic [3:0]  w_volley_len;
  logic [7:0]  w_wait_dec;
  logic        w_any_alive;
  logic        w_jump_done;

  // Next-tick target, phase and per-phase timing derived from the current inputs.
  always_comb begin
    w_tick       = bus.frame_tick && (bus.game_active == 2'd1);
    w_cur_alive  = r_target_sel ? bus.player_2_alive : bus.char_alive;
    w_oth_alive  = r_target_sel ? bus.char_alive : bus.player_2_alive;
    w_cur_aggro  = {1'b0, (r_target_sel ? bus.player_2_aggro : bus.char_aggro)};
    w_oth_aggro  = {1'b0, (r_target_sel ? bus.char_aggro : bus.player_2_aggro)};
    w_any_alive  = bus.char_alive || bus.player_2_alive;
    w_sel_n      = r_target_sel;
    if (!w_cur_alive && w_oth_alive) begin
      w_sel_n = ~r_target_sel;
    end else if (!w_cur_alive) begin
      w_sel_n = r_target_sel;
    end else if (w_oth_aggro >= (w_cur_aggro + {1'b0, AGGRO_HYST})) begin
      w_sel_n = ~r_target_sel;
    end else begin
      w_sel_n = r_target_sel;
    end
    w_tx_n = w_sel_n ? bus.player_2_x : bus.char_x;

    if (bus.boss_hp <= HP_PH3) begin
      w_hp_raw = 2'd3;
    end else if (bus.boss_hp <= HP_PH2) begin
      w_hp_raw = 2'd2;
    end else begin
      w_hp_raw = 2'd1;
    end
`ifdef BOSS_ENRAGE_EN
    w_hp_phase   = w_hp_raw;
`else
    w_hp_phase   = (w_hp_raw == 2'd3) ? 2'd2 : w_hp_raw;
`endif
    // Phase only ratchets upward while running.
    w_phase_n = (w_hp_phase > r_phase) ? w_hp_phase : r_phase;

    case (w_phase_n)
      2'd2:    begin w_wait_len = WAIT_P2; w_step_n = STEP_P2; end
      2'd3:    begin w_wait_len = WAIT_P3; w_step_n = STEP_P3; end
      default: begin w_wait_len = WAIT_P1; w_step_n = STEP_P1; end
    endcase
`ifdef BOSS_ENRAGE_EN
    w_volley_len = (w_phase_n == 2'd3) ? 4'd1 : JUMPS_PER_VOLLEY;
`else
    w_volley_len = JUMPS_PER_VOLLEY;
`endif

    w_wait_dec  = (bus.boss_grounded && (r_wait != 8'd0)) ? (r_wait - 8'd1) : r_wait;
    w_jump_done = (r_air && bus.boss_grounded) || ((r_jtick + 8'd1) >= JUMP_TIMEOUT);
  end

  // Scheduler FSM and all registered outputs; game_active==0 acts as a synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;  r_target_sel <= 1'b0;  r_target_x <= 12'd0;
      r_jump_req <= 1'b0; r_jump_dir <= 1'b1;    r_move_step <= STEP_P1;
      r_fire_req <= 1'b0; r_phase <= 2'd1;       r_enraged <= 1'b0;
      r_wait <= 8'd0;     r_jtick <= 8'd0;       r_air <= 1'b0;
      r_jumps <= 4'd0;    r_shots <= 2'd0;       r_gap <= 4'd0;
    end else if (bus.game_active == 2'd0) begin
      r_state <= S_IDLE;  r_target_sel <= 1'b0;  r_target_x <= 12'd0;
      r_jump_req <= 1'b0; r_jump_dir <= 1'b1;    r_move_step <= STEP_P1;
      r_fire_req <= 1'b0; r_phase <= 2'd1;       r_enraged <= 1'b0;
      r_wait <= 8'd0;     r_jtick <= 8'd0;       r_air <= 1'b0;
      r_jumps <= 4'd0;    r_shots <= 2'd0;       r_gap <= 4'd0;
    end else if (w_tick) begin
      r_jump_req   <= 1'b0;
      r_fire_req   <= 1'b0;
      r_target_sel <= w_sel_n;
      r_target_x   <= w_tx_n;
      r_phase      <= w_phase_n;
      r_move_step  <= w_step_n;
      r_enraged    <= (w_phase_n == 2'd3);
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT;
          r_wait  <= w_wait_len;
        end
        S_WAIT: begin
          if ((w_wait_dec == 8'd0) && w_any_alive) begin
            r_state    <= S_JUMP;
            r_jump_req <= 1'b1;
            r_jump_dir <= (w_tx_n < bus.boss_x) ? 1'b0 : 1'b1;
            r_wait     <= 8'd0;
            r_jtick    <= 8'd0;
            r_air      <= 1'b0;
          end else begin
            r_wait <= w_wait_dec;
          end
        end
        S_JUMP: begin
          if (w_jump_done) begin
            if ((r_jumps + 4'd1) >= w_volley_len) begin
              r_jumps <= 4'd0;
              r_state <= S_FIRE;
              r_shots <= w_phase_n;
              r_gap   <= 4'd0;
            end else begin
              r_jumps <= r_jumps + 4'd1;
              r_state <= S_WAIT;
              r_wait  <= w_wait_len;
            end
          end else begin
            r_jtick <= r_jtick + 8'd1;
            r_air   <= r_air || !bus.boss_grounded;
          end
        end
        S_FIRE: begin
          if (r_gap == 4'd0) begin
            r_fire_req <= 1'b1;
            if (r_shots <= 2'd1) begin
              r_state <= S_WAIT;
              r_wait  <= w_wait_len;
            end else begin
              r_shots <= r_shots - 2'd1;
              r_gap   <= SHOT_GAP - 4'd1;
            end
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      r_jump_req <= 1'b0;
      r_fire_req <= 1'b0;
    end
  end

  assign bus.target_sel = r_target_sel;
  assign bus.target_x   = r_target_x;
  assign bus.jump_req   = r_jump_req;
  assign bus.jump_dir   = r_jump_dir;
  assign bus.move_step  = r_move_step;
  assign bus.fire_req   = r_fire_req;
  assign bus.phase      = r_phase;
`ifdef BOSS_ENRAGE_EN
  assign bus.enraged    = r_enraged;
`else
  assign bus.enraged    = 1'b0;
`endif

endmodule

// File: tb/tb_boss_action_sched.sv
// Self-checking bench for boss_action_sched: arbitration table, directed timing sequences, random run vs model.
module tb_boss_action_sched;
  logic clk;
  logic rst_n;
  boss_action_sched_if bus();

  boss_action_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BOSS_ENRAGE_EN
  localparam bit ENR = 1'b1;
`else
  localparam bit ENR = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (game-rule level)
  localparam int M_IDLE = 0, M_WAIT = 1, M_JUMP = 2, M_FIRE = 3;
  int m_mode, m_sel, m_tx, m_jreq, m_jdir, m_step, m_freq, m_phase, m_enr;
  int m_wait_len, m_wait_done, m_jt, m_air, m_jumps, m_shots_total, m_fired, m_ft;

  function automatic int hp_phase(input int hp);
    if (ENR && hp <= 60) return 3;
    if (hp <= 140) return 2;
    return 1;
  endfunction
  function automatic int wait_for(input int p);
    return (p == 1) ? 30 : (p == 2) ? 20 : 10;
  endfunction
  function automatic int step_for(input int p);
    return (p == 1) ? 5 : (p == 2) ? 6 : 8;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_sel = 0; m_tx = 0; m_jreq = 0; m_jdir = 1; m_step = 5;
    m_freq = 0; m_phase = 1; m_enr = 0; m_wait_len = 0; m_wait_done = 0;
    m_jt = 0; m_air = 0; m_jumps = 0; m_shots_total = 0; m_fired = 0; m_ft = 0;
  endtask

  task automatic enter_wait(input int ph);
    m_mode = M_WAIT; m_wait_len = wait_for(ph); m_wait_done = 0;
  endtask

  task automatic model_posedge();
    int cur_ag, oth_ag, ph, need;
    bit cur_al, oth_al, g, done;
    if (!rst_n || bus.game_active == 2'd0) begin model_reset(); return; end
    m_jreq = 0; m_freq = 0;
    if (bus.game_active != 2'd1 || !bus.frame_tick) return;
    cur_al = (m_sel == 1) ? bus.player_2_alive : bus.char_alive;
    oth_al = (m_sel == 1) ? bus.char_alive : bus.player_2_alive;
    cur_ag = (m_sel == 1) ? int'(bus.player_2_aggro) : int'(bus.char_aggro);
    oth_ag = (m_sel == 1) ? int'(bus.char_aggro) : int'(bus.player_2_aggro);
    if (!cur_al && oth_al) m_sel = 1 - m_sel;
    else if (cur_al && oth_ag >= cur_ag + 2) m_sel = 1 - m_sel;
    m_tx = (m_sel == 1) ? int'(bus.player_2_x) : int'(bus.char_x);
    ph = hp_phase(int'(bus.boss_hp));
    if (ph < m_phase) ph = m_phase;
    m_phase = ph; m_step = step_for(ph); m_enr = (ph == 3) ? 1 : 0;
    g = bus.boss_grounded;
    case (m_mode)
      M_IDLE: enter_wait(ph);
      M_WAIT: begin
        if (g && m_wait_done < m_wait_len) m_wait_done++;
        if (m_wait_done == m_wait_len && (bus.char_alive || bus.player_2_alive)) begin
          m_mode = M_JUMP; m_jreq = 1; m_jdir = (m_tx < int'(bus.boss_x)) ? 0 : 1;
          m_jt = 0; m_air = 0;
        end
      end
      M_JUMP: begin
        m_jt++;
        done = (m_air == 1 && g) || m_jt >= 120;
        if (!done && !g) m_air = 1;
        if (done) begin
          m_jumps++;
          need = (ENR && ph == 3) ? 1 : 3;
          if (m_jumps >= need) begin
            m_jumps = 0; m_mode = M_FIRE; m_shots_total = ph; m_fired = 0; m_ft = 0;
          end else enter_wait(ph);
        end
      end
      default: begin
        if (m_ft % 8 == 0) begin
          m_freq = 1; m_fired++;
          if (m_fired == m_shots_total) enter_wait(ph);
        end
        m_ft++;
      end
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("m_target_sel", int'(bus.target_sel), m_sel);
    check("m_target_x",   int'(bus.target_x),   m_tx);
    check("m_jump_req",   int'(bus.jump_req),   m_jreq);
    check("m_jump_dir",   int'(bus.jump_dir),   m_jdir);
    check("m_move_step",  int'(bus.move_step),  m_step);
    check("m_fire_req",   int'(bus.fire_req),   m_freq);
    check("m_phase",      int'(bus.phase),      m_phase);
    check("m_enraged",    int'(bus.enraged),    m_enr);
  endtask

  // Called at a negedge; returns at the following negedge with outputs compared to the model.
  task automatic clk_cycle(input logic ft);
    bus.frame_tick = ft;
    @(posedge clk);
    model_posedge();
    @(negedge clk);
    bus.frame_tick = 1'b0;
    compare_all();
  endtask

  task automatic tick(output logic jr, output logic fr);
    clk_cycle(1'b1);
    jr = bus.jump_req;
    fr = bus.fire_req;
    clk_cycle(1'b0);
  endtask

  // Ticks until the wanted pulse; n=-1 if the budget runs out. other counts the other pulse kind.
  task automatic run_to(input bit want_fire, input int max, output int n, output int other);
    logic jr, fr;
    bit found;
    n = -1; other = 0; found = 0;
    for (int i = 1; i <= max && !found; i++) begin
      tick(jr, fr);
      if (want_fire ? fr : jr) begin n = i; found = 1; end
      else if (want_fire ? jr : fr) other++;
    end
  endtask

  task automatic land();
    logic jr, fr;
    bus.boss_grounded = 1'b0; tick(jr, fr);
    bus.boss_grounded = 1'b1; tick(jr, fr);
  endtask

  typedef struct {
    int ca; int pa; bit cal; bit pal; bit exp_sel;
  } arb_vec_t;
  arb_vec_t tbl[9];

  int n, other, pulses, prev_sel, hp;
  logic jr, fr;

  initial begin
    tbl[0] = '{5, 6, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{5, 7, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{6, 7, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{9, 7, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{9, 7, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{0, 0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{15, 15, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{15, 15, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{13, 15, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.frame_tick = 1'b0; bus.game_active = 2'd1; bus.boss_hp = 8'd200;
    bus.boss_x = 12'd960; bus.boss_grounded = 1'b1;
    bus.char_x = 12'd100; bus.player_2_x = 12'd100;
    bus.char_aggro = 4'd5; bus.player_2_aggro = 4'd5;
    bus.char_alive = 1'b1; bus.player_2_alive = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_target_sel", int'(bus.target_sel), 0);
    check("rst_target_x",   int'(bus.target_x),   0);
    check("rst_jump_dir",   int'(bus.jump_dir),   1);
    check("rst_move_step",  int'(bus.move_step),  5);
    check("rst_phase",      int'(bus.phase),      1);
    check("rst_pulses",     int'(bus.jump_req) + int'(bus.fire_req) + int'(bus.enraged), 0);
    rst_n = 1'b1;

    // Target arbitration table
    prev_sel = 0;
    for (int i = 0; i < 9; i++) begin
      bus.char_aggro = 4'(tbl[i].ca); bus.player_2_aggro = 4'(tbl[i].pa);
      bus.char_alive = tbl[i].cal;    bus.player_2_alive = tbl[i].pal;
      bus.char_x = 12'(100 + i);      bus.player_2_x = 12'(900 + i);
      clk_cycle(1'b0);
      check("arb_hold_no_tick", int'(bus.target_sel), prev_sel);
      tick(jr, fr);
      check("arb_sel", int'(bus.target_sel), int'(tbl[i].exp_sel));
      check("arb_x", int'(bus.target_x), tbl[i].exp_sel ? 900 + i : 100 + i);
      prev_sel = int'(tbl[i].exp_sel);
    end
    bus.game_active = 2'd0;
    clk_cycle(1'b0);
    check("sync_clear_sel", int'(bus.target_sel), 0);
    check("sync_clear_x",   int'(bus.target_x),   0);

    // First jump timing and direction
    bus.char_aggro = 4'd5; bus.player_2_aggro = 4'd5;
    bus.char_alive = 1'b1; bus.player_2_alive = 1'b1;
    bus.char_x = 12'd100;  bus.player_2_x = 12'd100;
    bus.game_active = 2'd1;
    run_to(1'b0, 40, n, other);
    check("first_jump_ticks", n, 31);
    check("first_jump_dir", int'(bus.jump_dir), 0);
    for (int k = 2; k <= 3; k++) begin
      land();
      run_to(1'b0, 40, n, other);
      check("p1_reload_wait", n, 30);
      check("p1_no_fire_in_wait", other, 0);
    end
    land();
    run_to(1'b1, 5, n, other);
    check("volley_first_shot", n, 1);
    run_to(1'b0, 40, n, other);
    check("p1_after_volley_wait", n, 30);
    check("p1_single_shot", other, 0);

    // Phase 2 volley: two shots 8 ticks apart
    bus.boss_hp = 8'd100;
    for (int k = 1; k <= 2; k++) begin
      land();
      run_to(1'b0, 40, n, other);
      check("p2_reload_wait", n, 20);
    end
    check("p2_phase", int'(bus.phase), 2);
    check("p2_step", int'(bus.move_step), 6);
    land();
    run_to(1'b1, 5, n, other);
    check("p2_first_shot", n, 1);
    run_to(1'b1, 20, n, other);
    check("p2_shot_gap", n, 8);
    run_to(1'b0, 40, n, other);
    check("p2_after_volley_wait", n, 20);
    check("p2_two_shots_only", other, 0);

    // Jump timeout with grounded stuck high
    run_to(1'b0, 200, n, other);
    check("timeout_then_wait", n, 140);
    check("timeout_no_fire", other, 0);

    // Async reset in the middle of a jump
    #2 rst_n = 1'b0;
    #1;
    check("arst_target_x",  int'(bus.target_x),  0);
    check("arst_jump_dir",  int'(bus.jump_dir),  1);
    check("arst_move_step", int'(bus.move_step), 5);
    check("arst_phase",     int'(bus.phase),     1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Phase escalation is monotonic
    bus.boss_hp = 8'd200;
    tick(jr, fr);
    check("esc_phase_start", int'(bus.phase), 1);
    bus.boss_hp = 8'd50;
    tick(jr, fr);
    check("esc_phase_low", int'(bus.phase), ENR ? 3 : 2);
    check("esc_enraged", int'(bus.enraged), ENR ? 1 : 0);
    check("esc_step", int'(bus.move_step), ENR ? 8 : 6);
    bus.boss_hp = 8'd200;
    tick(jr, fr);
    check("esc_phase_holds", int'(bus.phase), ENR ? 3 : 2);

    // Both players dead: no pulses
    bus.game_active = 2'd0; clk_cycle(1'b0);
    bus.char_alive = 1'b0; bus.player_2_alive = 1'b0; bus.game_active = 2'd1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick(jr, fr);
      pulses += int'(jr) + int'(fr);
    end
    check("dead_no_pulses", pulses, 0);

    // Randomized run against the model
    bus.char_alive = 1'b1; bus.player_2_alive = 1'b1;
    hp = 200;
    for (int c = 0; c < 6000; c++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin bus.game_active = 2'd0; hp = int'($urandom_range(150, 255)); end
      else if (r < 40) bus.game_active = 2'(2 + (r % 2));
      else bus.game_active = 2'd1;
      if ($urandom_range(0, 79) == 0) hp = (hp > 20) ? hp - int'($urandom_range(1, 20)) : 0;
      bus.boss_hp = 8'(hp);
      if ($urandom_range(0, 4) == 0) bus.boss_grounded = ~bus.boss_grounded;
      if ($urandom_range(0, 19) == 0) bus.char_aggro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) bus.player_2_aggro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) bus.char_alive = ~bus.char_alive;
      if ($urandom_range(0, 99) == 0) bus.player_2_alive = ~bus.player_2_alive;
      if ($urandom_range(0, 19) == 0) bus.char_x = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 19) == 0) bus.player_2_x = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 19) == 0) bus.boss_x = 12'($urandom_range(0, 4095));
      clk_cycle(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
